// File: rtl/scale_unit_arbiter.sv
// Round-robin arbiter sharing one "double value" datapath among NUM_REQ requesters.
// Accept -> compute (1 cycle) -> hold result until resp_ready; no new grant while a result is pending.
module scale_unit_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = 8,
  parameter bit SATURATE = 1'b0,
  localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [DATA_W-1:0]         resp_data,
  output logic [ID_W-1:0]           resp_id,
  output logic                      resp_ovf,
  output logic                      busy
);

  typedef enum logic [1:0] {IDLE, COMPUTE, RESPOND} state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [DATA_W-1:0]   op_q, op_d;
  logic                resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]   resp_data_q, resp_data_d;
  logic [ID_W-1:0]     resp_id_q, resp_id_d;
  logic                resp_ovf_q, resp_ovf_d;

  logic                gnt_found;
  logic [ID_W-1:0]     gnt_idx;
  logic                gnt_ok;
  int                  cand;

  // Shared datapath: returns {overflow, result}.
  function automatic logic [DATA_W:0] scale2(input logic [DATA_W-1:0] op);
    logic              ovf;
    logic [DATA_W-1:0] res;
    ovf = op[DATA_W-1];
    res = {op[DATA_W-2:0], 1'b0};
    if (SATURATE && ovf) res = '1;
    return {ovf, res};
  endfunction

  // Scan from farthest to nearest so the requester closest after the pointer wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = ptr_q;
    cand      = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = int'(ptr_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = ID_W'(cand);
      end
    end
  end

  assign gnt_ok    = (state_q == IDLE) && enable && gnt_found;
  assign req_ready = gnt_ok ? (NUM_REQ'(1) << gnt_idx) : '0;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    op_d         = op_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_id_d    = resp_id_q;
    resp_ovf_d   = resp_ovf_q;
    case (state_q)
      IDLE: begin
        if (gnt_ok) begin
          op_d    = req_data[int'(gnt_idx)*DATA_W +: DATA_W];
          ptr_d   = gnt_idx;
          state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        // The pointer still holds the granted index here.
        {resp_ovf_d, resp_data_d} = scale2(op_q);
        resp_id_d    = ptr_q;
        resp_valid_d = 1'b1;
        state_d      = RESPOND;
      end
      RESPOND: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= ID_W'(NUM_REQ - 1);
      op_q         <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_id_q    <= '0;
      resp_ovf_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      op_q         <= op_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_id_q    <= resp_id_d;
      resp_ovf_q   <= resp_ovf_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_id    = resp_id_q;
  assign resp_ovf   = resp_ovf_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_scale_unit_arbiter.sv
// Scoreboard bench: two instances (truncating and saturating) share all inputs.
module tb_scale_unit_arbiter;

  logic        clk = 1'b0;
  logic        rst_n, enable, resp_ready;
  logic [3:0]  req_valid;
  logic [31:0] req_data;

  logic [3:0]  req_ready, sat_req_ready;
  logic        resp_valid, sat_resp_valid;
  logic [7:0]  resp_data, sat_resp_data;
  logic [1:0]  resp_id, sat_resp_id;
  logic        resp_ovf, sat_resp_ovf;
  logic        busy, sat_busy;

  always #5 clk = ~clk;

  scale_unit_arbiter #(.NUM_REQ(4), .DATA_W(8), .SATURATE(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_id(resp_id), .resp_ovf(resp_ovf), .busy(busy)
  );

  scale_unit_arbiter #(.NUM_REQ(4), .DATA_W(8), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst_n(rst_n), .enable(enable), .req_valid(req_valid), .req_data(req_data),
    .req_ready(sat_req_ready), .resp_valid(sat_resp_valid), .resp_ready(resp_ready),
    .resp_data(sat_resp_data), .resp_id(sat_resp_id), .resp_ovf(sat_resp_ovf), .busy(sat_busy)
  );

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
    logic [7:0] sdata;
    logic       ovf;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   last_gcyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: compare on every response handshake, away from the clock edge.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (rst_n && resp_valid && resp_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_resp: got id %0d data %0h, expected no response", resp_id, resp_data);
      end else begin
        e = sb.pop_front();
        chk("resp_id", 32'(resp_id), 32'(e.id));
        chk("resp_data", 32'(resp_data), 32'(e.data));
        chk("resp_ovf", 32'(resp_ovf), 32'(e.ovf));
        chk("sat_resp_valid", 32'(sat_resp_valid), 32'd1);
        chk("sat_resp_id", 32'(sat_resp_id), 32'(e.id));
        chk("sat_resp_data", 32'(sat_resp_data), 32'(e.sdata));
        chk("sat_resp_ovf", 32'(sat_resp_ovf), 32'(e.ovf));
      end
    end
  end

  // Called at a falling edge; waits for a grant, checks it, returns at the falling edge after the accept.
  task automatic do_grant(input string name, input logic [3:0] exp_rdy, input logic [1:0] id,
                          input logic [7:0] d, input logic [7:0] sd, input logic ovf,
                          input bit drop, input bit push, output int waited);
    waited = 0;
    #1;
    while (req_ready == 4'b0 && waited < 40) begin
      @(negedge clk);
      #1;
      waited++;
    end
    chk({name, "_grant"}, 32'(req_ready), 32'(exp_rdy));
    chk({name, "_sat_grant"}, 32'(sat_req_ready), 32'(exp_rdy));
    last_gcyc = cyc;
    if (req_ready != 4'b0 && push) sb.push_back(exp_t'{id: id, data: d, sdata: sd, ovf: ovf});
    @(negedge clk);
    if (drop) req_valid[id] = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || sb.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_drain"}, 32'(busy || sb.size() != 0), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    req_valid = 4'b0;
    rst_n     = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [3:0] rr_rdy  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [1:0] rr_id   [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [7:0] rr_data [5] = '{8'h02, 8'h04, 8'h06, 8'h08, 8'h02};

  initial begin
    int w;
    int prev;
    rst_n      = 1'b0;
    enable     = 1'b1;
    resp_ready = 1'b1;
    req_valid  = 4'b0;
    req_data   = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_data", 32'(resp_data), 32'd0);
    chk("rst_resp_id", 32'(resp_id), 32'd0);
    chk("rst_resp_ovf", 32'(resp_ovf), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single request with latency checks.
    req_data[7:0] = 8'h15;
    req_valid     = 4'b0001;
    do_grant("single", 4'b0001, 2'd0, 8'h2A, 8'h2A, 1'b0, 1'b1, 1'b1, w);
    #1;
    chk("lat_compute_valid", 32'(resp_valid), 32'd0);
    chk("lat_compute_busy", 32'(busy), 32'd1);
    chk("lat_compute_rdy", 32'(req_ready), 32'd0);
    @(negedge clk);
    #1;
    chk("lat_respond_valid", 32'(resp_valid), 32'd1);
    wait_idle("single");

    // Overflow on requester 2.
    req_data[23:16] = 8'hC3;
    req_valid       = 4'b0100;
    do_grant("ovf", 4'b0100, 2'd2, 8'h86, 8'hFF, 1'b1, 1'b1, 1'b1, w);
    wait_idle("ovf");

    // Round robin from reset pointer, all requesters held valid.
    do_reset();
    req_data  = 32'h04030201;
    req_valid = 4'b1111;
    prev = 0;
    for (int i = 0; i < 5; i++) begin
      do_grant("rr", rr_rdy[i], rr_id[i], rr_data[i], rr_data[i], 1'b0, 1'b0, 1'b1, w);
      if (i > 0) chk("rr_spacing", 32'(last_gcyc - prev), 32'd3);
      prev = last_gcyc;
    end
    req_valid = 4'b0;
    wait_idle("rr");

    // Backpressure: result held, pending requester 0 not granted.
    resp_ready     = 1'b0;
    req_data[7:0]  = 8'h80;
    req_data[15:8] = 8'h7F;
    req_valid      = 4'b0011;
    do_grant("bp1", 4'b0010, 2'd1, 8'hFE, 8'hFE, 1'b0, 1'b1, 1'b1, w);
    repeat (5) begin
      @(negedge clk);
      #1;
      chk("bp_valid", 32'(resp_valid), 32'd1);
      chk("bp_data", 32'(resp_data), 32'hFE);
      chk("bp_id", 32'(resp_id), 32'd1);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    do_grant("bp2", 4'b0001, 2'd0, 8'h00, 8'hFF, 1'b1, 1'b1, 1'b1, w);
    chk("bp_release_wait", 32'(w), 32'd0);
    wait_idle("bp");

    // Enable gating, then enable dropped mid-transaction.
    do_reset();
    enable    = 1'b0;
    req_valid = 4'b1111;
    repeat (10) begin
      @(negedge clk);
      #1;
      chk("en_req_ready", 32'(req_ready), 32'd0);
      chk("en_busy", 32'(busy), 32'd0);
    end
    @(negedge clk);
    enable = 1'b1;
    do_grant("en", 4'b0001, 2'd0, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b1, w);
    req_valid = 4'b0;
    enable    = 1'b0;
    wait_idle("en");
    enable = 1'b1;

    // Reset during RESPOND discards the pending result.
    resp_ready     = 1'b0;
    req_data[15:8] = 8'h40;
    req_valid      = 4'b0010;
    do_grant("rst_mid", 4'b0010, 2'd1, 8'h80, 8'h80, 1'b0, 1'b1, 1'b0, w);
    @(negedge clk);
    #1;
    chk("rst_pre_valid", 32'(resp_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(resp_valid), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_data", 32'(resp_data), 32'd0);
    chk("rst_mid_sat_valid", 32'(sat_resp_valid), 32'd0);
    @(negedge clk);
    rst_n           = 1'b1;
    resp_ready      = 1'b1;
    req_data[23:16] = 8'h21;
    req_valid       = 4'b0100;
    do_grant("post_rst", 4'b0100, 2'd2, 8'h42, 8'h42, 1'b0, 1'b1, 1'b1, w);
    wait_idle("post_rst");

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
